// File: rtl/mult4_seq_if.sv
// Handshake and data bundle for the mult4_seq shift-and-add multiplier.
// The requester drives start/A/B; the multiplier returns P/busy/done.
interface mult4_seq_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic       busy;
  logic       done;

  modport master (output start, A, B, input  P, busy, done);
  modport slave  (input  start, A, B, output P, busy, done);
endinterface

// File: rtl/mult4_seq.sv
// 4x4 unsigned sequential shift-and-add multiplier around one sum4_v2 ripple adder.
// One iteration per clock: four iterations per product, result registered in P.

module sum4_v2 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in,
  output logic [3:0] S,
  output logic       c_out
);
  logic c1, c2, c3;

  assign S[0]  = A[0] ^ B[0] ^ c_in;
  assign c1    = (A[0] & B[0]) | (c_in & (A[0] ^ B[0]));
  assign S[1]  = A[1] ^ B[1] ^ c1;
  assign c2    = (A[1] & B[1]) | (c1 & (A[1] ^ B[1]));
  assign S[2]  = A[2] ^ B[2] ^ c2;
  assign c3    = (A[2] & B[2]) | (c2 & (A[2] ^ B[2]));
  assign S[3]  = A[3] ^ B[3] ^ c3;
  assign c_out = (A[3] & B[3]) | (c3 & (A[3] ^ B[3]));
endmodule

module mult4_seq (
  input  logic         clk,
  input  logic         reset,
  mult4_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] m, h, q;
  logic [1:0] cnt;
  logic [7:0] p;

  logic [3:0] addend, sum;
  logic       carry;
  logic [7:0] shifted;
  logic       accept;

  assign addend  = q[0] ? m : 4'b0000;
  // The carry is kept: it lands in h[3] after the right shift.
  assign shifted = {carry, sum, q[3:1]};
  assign accept  = bus.start && (state == IDLE || state == DONE);

  sum4_v2 u_adder (
    .A    (h),
    .B    (addend),
    .c_in (1'b0),
    .S    (sum),
    .c_out(carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == 2'd3) state_next = DONE;
      DONE:    state_next = bus.start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CALC);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m   <= '0;
      h   <= '0;
      q   <= '0;
      cnt <= '0;
      p   <= '0;
    end else if (accept) begin
      m   <= bus.A;
      q   <= bus.B;
      h   <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      {h, q} <= shifted;
      cnt    <= cnt + 2'd1;
      if (cnt == 2'd3) p <= shifted;
    end
  end

  assign bus.P = p;
endmodule

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq: vector table, hand-written corner sequences,
// and a done-driven scoreboard that compares P against queued expected products.
module tb_mult4_seq;
  logic clk = 1'b0;
  logic reset;
  mult4_seq_if bus_if ();

  mult4_seq dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse consumes one expected product.
  initial begin
    logic [7:0] e;
    forever begin
      tick();
      check("busy_done_exclusive", {31'd0, bus_if.busy & bus_if.done}, 0);
      if (bus_if.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("product", {24'd0, bus_if.P}, {24'd0, e});
        end
      end
    end
  end

  // Single operation from IDLE with full cycle-by-cycle timing checks.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    bus_if.A = a;
    bus_if.B = b;
    bus_if.start = 1'b1;
    exp_q.push_back(p);
    tick();
    bus_if.start = 1'b0;
    bus_if.A = 4'($urandom);
    bus_if.B = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      check("busy_in_calc", {31'd0, bus_if.busy}, 1);
      check("no_done_in_calc", {31'd0, bus_if.done}, 0);
      tick();
    end
    check("done_at_latency4", {31'd0, bus_if.done}, 1);
    tick();
    check("done_one_cycle", {31'd0, bus_if.done}, 0);
    check("idle_after_done", {31'd0, bus_if.busy}, 0);
    tick();
    check("p_holds", {24'd0, bus_if.P}, {24'd0, p});
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   d0;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'd15};
    vecs[1] = '{a: 4'd0,  b: 4'd0,  p: 8'd0};
    vecs[2] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[3] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
    vecs[4] = '{a: 4'd1,  b: 4'd15, p: 8'd15};
    vecs[5] = '{a: 4'd10, b: 4'd11, p: 8'd110};
    vecs[6] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};

    // Reset held two cycles with start asserted.
    reset = 1'b1;
    bus_if.start = 1'b1;
    bus_if.A = 4'd5;
    bus_if.B = 4'd5;
    tick();
    tick();
    check("reset_p", {24'd0, bus_if.P}, 0);
    check("reset_busy", {31'd0, bus_if.busy}, 0);
    check("reset_done", {31'd0, bus_if.done}, 0);
    bus_if.start = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_after_reset", {31'd0, bus_if.busy}, 0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Start during CALC is ignored; exactly one done.
    d0 = done_cnt;
    bus_if.A = 4'd7;
    bus_if.B = 4'd9;
    bus_if.start = 1'b1;
    exp_q.push_back(8'd63);
    tick();
    bus_if.start = 1'b0;
    tick();
    bus_if.A = 4'd2;
    bus_if.B = 4'd2;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    drain(10);
    repeat (8) tick();
    check("ignored_start_one_done", done_cnt - d0, 1);
    check("ignored_start_p", {24'd0, bus_if.P}, 63);

    // Reset mid-CALC aborts without done.
    d0 = done_cnt;
    bus_if.A = 4'd6;
    bus_if.B = 4'd6;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_p", {24'd0, bus_if.P}, 0);
    check("abort_busy", {31'd0, bus_if.busy}, 0);
    check("abort_done", {31'd0, bus_if.done}, 0);
    reset = 1'b0;
    repeat (8) tick();
    check("abort_no_done", done_cnt - d0, 0);
    run_op(4'd4, 4'd4, 8'd16);

    // start held high: done every 5 cycles.
    bus_if.A = 4'd10;
    bus_if.B = 4'd11;
    bus_if.start = 1'b1;
    repeat (3) exp_q.push_back(8'd110);
    tick();
    for (int j = 0; j < 3; j++) begin
      repeat (4) tick();
      check("b2b_done_period", {31'd0, bus_if.done}, 1);
      if (j == 2) bus_if.start = 1'b0;
      tick();
      check("b2b_busy_after", {31'd0, bus_if.busy}, (j == 2) ? 32'd0 : 32'd1);
    end
    drain(10);

    // Exhaustive sweep against the A*B model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus_if.A = 4'(a);
        bus_if.B = 4'(b);
        bus_if.start = 1'b1;
        exp_q.push_back(8'(a * b));
        tick();
        bus_if.start = 1'b0;
        repeat (5) tick();
      end
    end
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
